// File: rtl/cim_unit.sv
// Compute-in-memory unit: banked weight store with a row read/write port and a
// single-cycle MAC engine producing one partial sum per weight column.
module cim_unit #(
    parameter int unsigned NUM_CORES = 8,
    parameter int unsigned ROWS      = 64,
    parameter int unsigned COLS      = 72,
    parameter int unsigned WBITS     = 4,
    parameter int unsigned ABITS     = 4,
    parameter int unsigned PBITS     = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [$clog2(NUM_CORES)-1:0] CIM_Core_A,
    input  logic                       CIM_en,
    input  logic                       STR_en,
    input  logic                       STDW,
    input  logic                       STDR,
    input  logic [$clog2(NUM_CORES)-1:0] STD_Core_A,
    input  logic [$clog2(ROWS)-1:0]    STD_row_A,
    input  logic [COLS*WBITS-1:0]      weight_in,
    input  logic [ROWS*ABITS-1:0]      act_in1,
    input  logic [ROWS*ABITS-1:0]      act_in2,
    input  logic [ROWS*ABITS-1:0]      act_in3,
    output logic [COLS*WBITS-1:0]      weight_out,
    output logic [COLS*PBITS-1:0]      PSUM
);

    localparam int unsigned ROW_AW = $clog2(ROWS);
    // Columns are split into three equal groups, each fed by its own activation bus.
    localparam int unsigned GRP    = COLS / 3;

    logic [COLS*WBITS-1:0] r_mem [NUM_CORES][ROWS];
    logic [COLS*WBITS-1:0] r_wout;
    logic [COLS*PBITS-1:0] r_psum;
    logic [PBITS-1:0]      w_sum [COLS];
    logic [ROWS*ABITS-1:0] w_act_grp;
    logic [COLS*PBITS-1:0] w_psum_d;

    // Weight storage: row write, no reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (STDW) begin
            r_mem[STD_Core_A][STD_row_A] <= weight_in;
        end
    end

    // Dot product of every column of the selected core with its activation group.
    // Reads the pre-edge memory, so a same-edge write does not affect the result.
    always_comb begin
        w_act_grp = '0;
        for (int c = 0; c < COLS; c++) begin
            if (c < GRP) begin
                w_act_grp = act_in1;
            end else if (c < 2 * GRP) begin
                w_act_grp = act_in2;
            end else begin
                w_act_grp = act_in3;
            end
            w_sum[c] = '0;
            for (int r = 0; r < ROWS; r++) begin
                w_sum[c] = w_sum[c]
                         + PBITS'(r_mem[CIM_Core_A][ROW_AW'(r)][c*WBITS +: WBITS])
                         * PBITS'(w_act_grp[r*ABITS +: ABITS]);
            end
        end
    end

    // Next partial sums: overwrite or accumulate with modulo-2^PBITS wrap.
    always_comb begin
        w_psum_d = r_psum;
        for (int c = 0; c < COLS; c++) begin
            if (STR_en) begin
                w_psum_d[c*PBITS +: PBITS] = r_psum[c*PBITS +: PBITS] + w_sum[c];
            end else begin
                w_psum_d[c*PBITS +: PBITS] = w_sum[c];
            end
        end
    end

    // Output registers: row read data (write wins over read) and partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wout <= '0;
            r_psum <= '0;
        end else begin
            if (STDR && !STDW) begin
                r_wout <= r_mem[STD_Core_A][STD_row_A];
            end
            if (CIM_en) begin
                r_psum <= w_psum_d;
            end
        end
    end

    assign weight_out = r_wout;
    assign PSUM       = r_psum;

endmodule

// File: tb/tb_cim_unit.sv
// Directed self-checking bench for cim_unit.
module tb_cim_unit;

    logic           clk;
    logic           rst_n;
    logic [2:0]     CIM_Core_A;
    logic           CIM_en;
    logic           STR_en;
    logic           STDW;
    logic           STDR;
    logic [2:0]     STD_Core_A;
    logic [5:0]     STD_row_A;
    logic [287:0]   weight_in;
    logic [255:0]   act_in1;
    logic [255:0]   act_in2;
    logic [255:0]   act_in3;
    logic [287:0]   weight_out;
    logic [1007:0]  PSUM;

    int n_checks;
    int n_fail;

    logic [13:0]    exp_col [72];
    logic [287:0]   wrow;

    cim_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CIM_Core_A (CIM_Core_A),
        .CIM_en     (CIM_en),
        .STR_en     (STR_en),
        .STDW       (STDW),
        .STDR       (STDR),
        .STD_Core_A (STD_Core_A),
        .STD_row_A  (STD_row_A),
        .weight_in  (weight_in),
        .act_in1    (act_in1),
        .act_in2    (act_in2),
        .act_in3    (act_in3),
        .weight_out (weight_out),
        .PSUM       (PSUM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1007:0] got,
                             input logic [1007:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [287:0] rep_w(input logic [3:0] v);
        logic [287:0] x;
        for (int c = 0; c < 72; c++) x[c*4 +: 4] = v;
        return x;
    endfunction

    function automatic logic [255:0] rep_a(input logic [3:0] v);
        logic [255:0] x;
        for (int r = 0; r < 64; r++) x[r*4 +: 4] = v;
        return x;
    endfunction

    function automatic logic [1007:0] pack_exp();
        logic [1007:0] x;
        for (int c = 0; c < 72; c++) x[c*14 +: 14] = exp_col[c];
        return x;
    endfunction

    function automatic logic [1007:0] rep_p(input logic [13:0] v);
        logic [1007:0] x;
        for (int c = 0; c < 72; c++) x[c*14 +: 14] = v;
        return x;
    endfunction

    // One clock: inputs set at negedge are taken at posedge, strobes dropped after.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        STDW   = 1'b0;
        STDR   = 1'b0;
        CIM_en = 1'b0;
        STR_en = 1'b0;
    endtask

    task automatic write_row(input logic [2:0] core, input logic [5:0] row,
                             input logic [287:0] data);
        STDW       = 1'b1;
        STD_Core_A = core;
        STD_row_A  = row;
        weight_in  = data;
        cycle();
    endtask

    task automatic read_row(input logic [2:0] core, input logic [5:0] row);
        STDR       = 1'b1;
        STD_Core_A = core;
        STD_row_A  = row;
        cycle();
    endtask

    task automatic compute(input logic [2:0] core, input logic str,
                           input logic [255:0] a1, input logic [255:0] a2,
                           input logic [255:0] a3);
        CIM_en     = 1'b1;
        STR_en     = str;
        CIM_Core_A = core;
        act_in1    = a1;
        act_in2    = a2;
        act_in3    = a3;
        cycle();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        CIM_Core_A = '0;
        CIM_en     = 1'b0;
        STR_en     = 1'b0;
        STDW       = 1'b0;
        STDR       = 1'b0;
        STD_Core_A = '0;
        STD_row_A  = '0;
        weight_in  = '0;
        act_in1    = '0;
        act_in2    = '0;
        act_in3    = '0;
        #12;
        check_val("reset_wout", weight_out, '0);
        check_val("reset_psum", PSUM, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Core 4 all ones, core 2 all 0xF.
        for (int r = 0; r < 64; r++) write_row(3'd4, 6'(r), rep_w(4'h1));
        for (int r = 0; r < 64; r++) write_row(3'd2, 6'(r), rep_w(4'hF));
        read_row(3'd4, 6'd35);
        check_val("read_c4_r35", weight_out, rep_w(4'h1));
        check_val("psum_idle", PSUM, '0);

        compute(3'd4, 1'b0, rep_a(4'h1), rep_a(4'h1), rep_a(4'h1));
        check_val("mac_ones", PSUM, rep_p(14'd64));

        compute(3'd2, 1'b0, rep_a(4'hF), rep_a(4'hF), rep_a(4'hF));
        check_val("mac_max", PSUM, rep_p(14'd14400));
        compute(3'd2, 1'b1, rep_a(4'hF), rep_a(4'hF), rep_a(4'hF));
        check_val("mac_acc_wrap", PSUM, rep_p(14'd12416));

        compute(3'd4, 1'b0, rep_a(4'h1), rep_a(4'h2), rep_a(4'h0));
        for (int c = 0; c < 72; c++) exp_col[c] = (c < 24) ? 14'd64 : (c < 48) ? 14'd128 : 14'd0;
        check_val("mac_groups", PSUM, pack_exp());
        cycle();
        check_val("psum_hold", PSUM, pack_exp());

        // Core 5: only row 5 non-zero, weight c%16; activation r = r%16 -> col c = 5*(c%16).
        for (int c = 0; c < 72; c++) wrow[c*4 +: 4] = 4'(c % 16);
        for (int r = 0; r < 64; r++) write_row(3'd5, 6'(r), (r == 5) ? wrow : '0);
        for (int r = 0; r < 64; r++) act_in1[r*4 +: 4] = 4'(r % 16);
        compute(3'd5, 1'b0, act_in1, act_in1, act_in1);
        for (int c = 0; c < 72; c++) exp_col[c] = 14'(5 * (c % 16));
        check_val("mac_pattern", PSUM, pack_exp());
        read_row(3'd5, 6'd5);
        check_val("read_pattern", weight_out, wrow);

        // Same-edge write/read/compute on core 3 row 26.
        for (int r = 0; r < 64; r++) write_row(3'd3, 6'(r), rep_w(4'h1));
        read_row(3'd2, 6'd0);
        check_val("read_c2_r0", weight_out, rep_w(4'hF));
        STDW       = 1'b1;
        STDR       = 1'b1;
        STD_Core_A = 3'd3;
        STD_row_A  = 6'd26;
        weight_in  = rep_w(4'h2);
        compute(3'd3, 1'b0, rep_a(4'h1), rep_a(4'h1), rep_a(4'h1));
        check_val("same_edge_wout_hold", weight_out, rep_w(4'hF));
        check_val("same_edge_old_weights", PSUM, rep_p(14'd64));
        read_row(3'd3, 6'd26);
        check_val("read_after_write", weight_out, rep_w(4'h2));
        compute(3'd3, 1'b0, rep_a(4'h1), rep_a(4'h1), rep_a(4'h1));
        check_val("mac_new_weights", PSUM, rep_p(14'd65));

        // Asynchronous reset mid-cycle, then memory must still hold its contents.
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_wout", weight_out, '0);
        check_val("async_rst_psum", PSUM, '0);
        @(negedge clk);
        rst_n = 1'b1;
        read_row(3'd3, 6'd26);
        check_val("mem_persists", weight_out, rep_w(4'h2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
